// File: rtl/matrix_scan_ctrl_if.sv
// Panel-side bundle of the HUB75 scan generator: addresses, strobes, mask.
// master drives the pins/addresses, slave is the frame buffer / pin mux.
interface matrix_scan_ctrl_if #(
   parameter int COL_W = 6,
   parameter int ROW_W = 4,
   parameter int BITS  = 6
);
   logic [COL_W-1:0] column_address;
   logic [ROW_W-1:0] row_address;
   logic [ROW_W-1:0] row_address_active;
   logic             clk_pixel_load;
   logic             clk_pixel;
   logic             row_latch;
   logic             output_enable;
   logic [BITS-1:0]  brightness_mask;

   modport master (
      output column_address, row_address, row_address_active,
             clk_pixel_load, clk_pixel, row_latch,
             output_enable, brightness_mask
   );

   modport slave (
      input  column_address, row_address, row_address_active,
             clk_pixel_load, clk_pixel, row_latch,
             output_enable, brightness_mask
   );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// HUB75 scan/timing generator: SHIFT -> LATCH -> DISPLAY, binary-coded planes.
// Define MATRIX_SCAN_BLANK_EN to insert a BLANK settle state after LATCH.
module matrix_scan_ctrl #(
   parameter int PIXELS_PER_ROW  = 64,
   parameter int ROW_PAIRS       = 16,
   parameter int BRIGHTNESS_BITS = 6,
   parameter int BASE_ON_CYCLES  = 4,
   parameter int BLANK_CYCLES    = 4
) (
   input logic                clk_in,
   input logic                reset,
   matrix_scan_ctrl_if.master scan
);
   localparam int COL_W     = $clog2(PIXELS_PER_ROW);
   localparam int ROW_W     = $clog2(ROW_PAIRS);
   localparam int PL_W      = (BRIGHTNESS_BITS > 1) ? $clog2(BRIGHTNESS_BITS) : 1;
   localparam int SHIFT_LEN = 2 * PIXELS_PER_ROW;
   localparam int DISP_MAX  = BASE_ON_CYCLES << (BRIGHTNESS_BITS - 1);
   localparam int CNT_MAX   = (SHIFT_LEN > DISP_MAX) ? SHIFT_LEN : DISP_MAX;
   localparam int CNT_W     = $clog2(CNT_MAX) + 1;

   typedef enum logic [1:0] {SHIFT, LATCH, BLANK, DISPLAY} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, disp_len;
   logic [PL_W-1:0]  plane, plane_n;
   logic [ROW_W-1:0] row, row_n;

   assign disp_len = CNT_W'(BASE_ON_CYCLES) << plane;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state <= SHIFT;
         cnt   <= '0;
         plane <= '0;
         row   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         plane <= plane_n;
         row   <= row_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      plane_n = plane;
      row_n   = row;
      unique case (state)
         SHIFT: begin
            if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
               state_n = LATCH;
               cnt_n   = '0;
            end
         end
         LATCH: begin
            cnt_n = '0;
`ifdef MATRIX_SCAN_BLANK_EN
            state_n = BLANK;
`else
            state_n = DISPLAY;
`endif
         end
         BLANK: begin
            if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
               state_n = DISPLAY;
               cnt_n   = '0;
            end
         end
         DISPLAY: begin
            if (cnt == disp_len - 1'b1) begin
               state_n = SHIFT;
               cnt_n   = '0;
               // last plane of the row: wrap mask and move to next row pair
               if (plane == PL_W'(BRIGHTNESS_BITS - 1)) begin
                  plane_n = '0;
                  row_n   = (row == ROW_W'(ROW_PAIRS - 1)) ? '0 : row + 1'b1;
               end else begin
                  plane_n = plane + 1'b1;
               end
            end
         end
         default: begin
            state_n = SHIFT;
            cnt_n   = '0;
         end
      endcase
   end

   // Pins are a registered decode of the sequencer, one cycle behind it.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         scan.column_address     <= '0;
         scan.row_address        <= '0;
         scan.row_address_active <= '0;
         scan.clk_pixel_load     <= 1'b0;
         scan.clk_pixel          <= 1'b0;
         scan.row_latch          <= 1'b0;
         scan.output_enable      <= 1'b0;
         scan.brightness_mask    <= BRIGHTNESS_BITS'(1);
      end else begin
         scan.clk_pixel_load  <= (state == SHIFT) && !cnt[0];
         scan.clk_pixel       <= (state == SHIFT) && cnt[0];
         scan.row_latch       <= (state == LATCH);
         scan.output_enable   <= (state == DISPLAY);
         scan.brightness_mask <= BRIGHTNESS_BITS'(1) << plane;
         scan.row_address     <= row;
         if (state == SHIFT)
            scan.column_address <= cnt[COL_W:1];
         if (scan.row_latch)
            scan.row_address_active <= scan.row_address;
      end
   end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: cycle-exact reference computed from the
// scan schedule arithmetic, plus random mid-operation resets.
module tb_matrix_scan_ctrl;
`ifdef MATRIX_SCAN_BLANK_EN
   localparam int BL = 4;
`else
   localparam int BL = 0;
`endif
   localparam int NPIX  = 64;
   localparam int ROWP  = 6 * (2 * NPIX + 1 + BL) + 4 * 63;
   localparam int FRAME = 16 * ROWP;

   typedef struct packed {
      logic [5:0] col;
      logic [3:0] row;
      logic [3:0] act;
      logic       load;
      logic       clk;
      logic       lat;
      logic       oe;
      logic [5:0] mask;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   t = 0;
   int   checks = 0;
   int   errors = 0;

   matrix_scan_ctrl_if #(.COL_W(6), .ROW_W(4), .BITS(6)) bus ();

   matrix_scan_ctrl dut (
      .clk_in (clk),
      .reset  (reset),
      .scan   (bus.master)
   );

   always #5 clk = ~clk;

   function automatic int plen(int b);
      return 2 * NPIX + 1 + BL + (4 << b);
   endfunction

   // Expected pins at output cycle t (t=0 is the first cycle after reset).
   function automatic exp_t model(int tt);
      exp_t e;
      int u, r, o, b;
      e = '0;
      e.mask = 6'd1;
      if (tt == 0) return e;
      u = (tt - 1) % FRAME;
      r = u / ROWP;
      o = u % ROWP;
      b = 0;
      while (o >= plen(b)) begin
         o -= plen(b);
         b++;
      end
      e.row  = 4'(r);
      e.mask = 6'(1 << b);
      if (o < 2 * NPIX) begin
         e.col  = 6'(o / 2);
         e.load = (o % 2 == 0);
         e.clk  = (o % 2 == 1);
      end else if (o == 2 * NPIX) begin
         e.lat = 1'b1;
      end else if (o >= 2 * NPIX + 1 + BL) begin
         e.oe = 1'b1;
      end
      if (tt - 1 <= 2 * NPIX) e.act = 4'd0;
      else if (o > 2 * NPIX || b > 0) e.act = 4'(r);
      else e.act = 4'((r + 15) % 16);
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.col  = bus.column_address;
      o.row  = bus.row_address;
      o.act  = bus.row_address_active;
      o.load = bus.clk_pixel_load;
      o.clk  = bus.clk_pixel;
      o.lat  = bus.row_latch;
      o.oe   = bus.output_enable;
      o.mask = bus.brightness_mask;
      // column only defined by the schedule while shifting
      if (!(bus.clk_pixel_load || bus.clk_pixel)) o.col = '0;
      return o;
   endfunction

   function automatic exp_t model_obs(int tt);
      exp_t e;
      e = model(tt);
      if (!(e.load || e.clk)) e.col = '0;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      t = 0;
   endtask

   task automatic test_reset();
      exp_t o, e;
      do_reset();
      o = observe();
      e = model(0);
      checks++;
      if ({bus.column_address, o} !== {6'd0, e}) begin
         errors++;
         $display("FAIL reset_state got=%h col=%0d exp=%h", o, bus.column_address, e);
      end
   endtask

   task automatic test_shift();
      exp_t o, e;
      int rises, loads, k, n;
      logic prev;
      do_reset();
      rises = 0;
      loads = 0;
      prev = bus.clk_pixel;
      repeat (2 * NPIX) begin
         step();
         o = observe();
         e = model_obs(t);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL shift t=%0d got=%h exp=%h", t, o, e);
         end
         if (bus.clk_pixel && !prev) rises++;
         if (bus.clk_pixel_load) loads++;
         prev = bus.clk_pixel;
      end
      checks++;
      if (rises != NPIX || loads != NPIX) begin
         errors++;
         $display("FAIL shift_edges rises=%0d loads=%0d exp=%0d", rises, loads, NPIX);
      end
      step();
      checks++;
      if (bus.row_latch !== 1'b1 || bus.output_enable !== 1'b0) begin
         errors++;
         $display("FAIL latch_pulse lat=%b oe=%b exp lat=1 oe=0", bus.row_latch, bus.output_enable);
      end
      k = 0;
      while (bus.output_enable !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      checks++;
      if (k != BL + 1) begin
         errors++;
         $display("FAIL latch_to_oe got=%0d exp=%0d", k, BL + 1);
      end
      n = 0;
      while (bus.output_enable === 1'b1 && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (n != 4 || bus.row_address_active !== 4'd0) begin
         errors++;
         $display("FAIL plane0_on got=%0d act=%0d exp=4 act=0", n, bus.row_address_active);
      end
   endtask

   task automatic test_row();
      exp_t o, e;
      int runs[$];
      int n;
      do_reset();
      n = 0;
      while (t < ROWP + 1) begin
         step();
         o = observe();
         e = model_obs(t);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL row t=%0d got=%h exp=%h", t, o, e);
         end
         if (bus.output_enable) n++;
         else if (n > 0) begin
            runs.push_back(n);
            n = 0;
         end
      end
      checks++;
      if (runs.size() != 6) begin
         errors++;
         $display("FAIL row_planes got=%0d exp=6", runs.size());
      end
      for (int i = 0; i < runs.size() && i < 6; i++) begin
         checks++;
         if (runs[i] != (4 << i)) begin
            errors++;
            $display("FAIL oe_time plane=%0d got=%0d exp=%0d", i, runs[i], 4 << i);
         end
      end
      checks++;
      if (bus.row_address !== 4'd1 || bus.brightness_mask !== 6'b000001) begin
         errors++;
         $display("FAIL row_inc row=%0d mask=%b exp row=1 mask=000001",
                  bus.row_address, bus.brightness_mask);
      end
   endtask

   task automatic test_frame();
      exp_t o, e;
      logic [3:0] r_last, r_wrap;
      do_reset();
      r_last = 'x;
      r_wrap = 'x;
      while (t < FRAME + ROWP) begin
         step();
         o = observe();
         e = model_obs(t);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL frame t=%0d got=%h exp=%h", t, o, e);
         end
         if (t == FRAME) r_last = bus.row_address;
         if (t == FRAME + 1) r_wrap = bus.row_address;
      end
      checks++;
      if (r_last !== 4'd15 || r_wrap !== 4'd0) begin
         errors++;
         $display("FAIL row_wrap got=%0d,%0d exp=15,0", r_last, r_wrap);
      end
   endtask

   task automatic test_reset_mid_display();
      exp_t o, e;
      int target;
      bit found;
      for (int it = 0; it < 4; it++) begin
         target = t + $urandom_range(50, 3000);
         found = 0;
         while (t < target + 2000 && !found) begin
            step();
            o = observe();
            e = model_obs(t);
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL pre_reset it=%0d t=%0d got=%h exp=%h", it, t, o, e);
            end
            if (t >= target && bus.output_enable === 1'b1) found = 1;
         end
         checks++;
         if (!found) begin
            errors++;
            $display("FAIL find_display it=%0d got=none exp=oe", it);
         end
         do_reset();
         checks++;
         if (bus.output_enable !== 1'b0 || bus.column_address !== 6'd0 ||
             bus.row_address !== 4'd0 || bus.brightness_mask !== 6'b000001) begin
            errors++;
            $display("FAIL mid_reset it=%0d oe=%b col=%0d row=%0d mask=%b exp 0,0,0,000001",
                     it, bus.output_enable, bus.column_address, bus.row_address,
                     bus.brightness_mask);
         end
         repeat (2 * NPIX + 10) begin
            step();
            o = observe();
            e = model_obs(t);
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL restart it=%0d t=%0d got=%h exp=%h", it, t, o, e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_shift();
      test_row();
      test_frame();
      test_reset_mid_display();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
